// File: rtl/dht_read_scheduler.sv
// Read scheduler for an external DHT11 transaction engine: power-on wait, read spacing,
// timeout/retry accounting, last-good-frame latch and over-temperature flag with hysteresis.
module dht_read_scheduler #(
    parameter int unsigned CLK_PER_US  = 50,
    parameter int unsigned POWER_ON_US = 1000000,
    parameter int unsigned INTERVAL_US = 2000000,
    parameter int unsigned TIMEOUT_US  = 50000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TH_HI       = 30,
    parameter int unsigned TH_LO       = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        eng_start,
    output logic        eng_abort,
    input  logic        eng_done,
    input  logic        eng_ok,
    input  logic [31:0] eng_data,
    output logic [31:0] data_valid,
    output logic        valid,
    output logic        stale,
    output logic        fault,
    output logic [7:0]  err_count,
    output logic        TH,
    output logic        busy
);

    typedef enum logic [2:0] {
        StPowerOn,
        StIdle,
        StStart,
        StWaitDone,
        StWaitInterval
    } state_e;

    localparam int unsigned PreW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(CLK_PER_US - 1);
    localparam logic [21:0] PowerOnCnt  = 22'(POWER_ON_US);
    localparam logic [21:0] IntervalCnt = 22'(INTERVAL_US);
    localparam logic [21:0] TimeoutCnt  = 22'(TIMEOUT_US);
    localparam logic [3:0]  MaxRetry    = 4'(MAX_RETRY);
    localparam logic [7:0]  ThHi        = 8'(TH_HI);
    localparam logic [7:0]  ThLo        = 8'(TH_LO);

    state_e state_q, state_d;
    logic [PreW-1:0] pre_q;
    logic [21:0] us_cnt_q;
    logic        us_tick;
    logic        timeout;
    logic        attempt_ok;
    logic        attempt_fail;
    logic [3:0]  fail_q;
    logic [4:0]  fail_next;
    logic [7:0]  temp;

    logic [31:0] data_q;
    logic        valid_q, stale_q, fault_q, th_q;
    logic [7:0]  err_q;

    assign us_tick   = (pre_q == PreMax);
    assign timeout   = (us_cnt_q >= TimeoutCnt);
    assign fail_next = {1'b0, fail_q} + 5'd1;
    assign temp      = eng_data[15:8];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StPowerOn;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPowerOn: begin
                if (us_cnt_q >= PowerOnCnt) state_d = enable ? StStart : StIdle;
            end
            StIdle: begin
                if (enable) state_d = StWaitInterval;
            end
            StStart: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (eng_done || timeout) state_d = StWaitInterval;
            end
            StWaitInterval: begin
                if (us_cnt_q >= IntervalCnt) state_d = enable ? StStart : StIdle;
            end
            default: begin
                state_d = StPowerOn;
            end
        endcase
    end

    // Output decode; eng_done beats a coincident timeout
    always_comb begin
        eng_start    = (state_q == StStart);
        busy         = (state_q == StStart) || (state_q == StWaitDone);
        eng_abort    = (state_q == StWaitDone) && timeout && !eng_done;
        attempt_ok   = (state_q == StWaitDone) && eng_done && eng_ok;
        attempt_fail = (state_q == StWaitDone) && (eng_done ? !eng_ok : timeout);
    end

    // Free-running prescaler; the us counter restarts on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            us_cnt_q <= '0;
        end else begin
            pre_q <= us_tick ? '0 : pre_q + 1'b1;
            if (state_d != state_q) begin
                us_cnt_q <= '0;
            end else if (us_tick) begin
                us_cnt_q <= us_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            stale_q <= 1'b0;
            fault_q <= 1'b0;
            th_q    <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else if (attempt_ok) begin
            data_q  <= eng_data;
            valid_q <= 1'b1;
            stale_q <= 1'b0;
            fault_q <= 1'b0;
            fail_q  <= '0;
            if (temp > ThHi) begin
                th_q <= 1'b1;
            end else if (temp < ThLo) begin
                th_q <= 1'b0;
            end
        end else if (attempt_fail) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (fail_next >= {1'b0, MaxRetry}) begin
                fault_q <= 1'b1;
                stale_q <= 1'b1;
                fail_q  <= MaxRetry;
            end else begin
                fail_q <= fail_next[3:0];
            end
        end
    end

    assign data_valid = data_q;
    assign valid      = valid_q;
    assign stale      = stale_q;
    assign fault      = fault_q;
    assign TH         = th_q;
    assign err_count  = err_q;

endmodule
